// File: rtl/parity_pkg.sv
// Shared parity definitions: parity-sense constants and
// the state encoding of the two-entry output buffer.
package parity_pkg;

  localparam logic PARITY_ODD  = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer; all outputs registered.
// Ports: push_i/pop_i strobes, din_i in, rdy_o/vld_o/dout_o out.
module skid_buf2
  import parity_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         rdy_o,
  output logic         vld_o,
  output logic [W-1:0] dout_o
);

  buf_state_e   state_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         rdy_q;
  logic         vld_q;

  // rdy_q is held low through reset and only rises on the
  // first edge after release, so it is a flop, not a decode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          rdy_q <= 1'b1;
          if (push_i) begin
            head_q  <= din_i;
            vld_q   <= 1'b1;
            state_q <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({push_i, pop_i})
            2'b11: head_q <= din_i;
            2'b10: begin
              tail_q  <= din_i;
              rdy_q   <= 1'b0;
              state_q <= BUF_FULL;
            end
            2'b01: begin
              vld_q   <= 1'b0;
              state_q <= BUF_EMPTY;
            end
            default: ;
          endcase
        end
        BUF_FULL: begin
          if (pop_i) begin
            head_q  <= tail_q;
            rdy_q   <= 1'b1;
            state_q <= BUF_ONE;
          end
        end
        default: begin
          rdy_q   <= 1'b0;
          vld_q   <= 1'b0;
          state_q <= BUF_EMPTY;
        end
      endcase
    end
  end

  assign rdy_o  = rdy_q;
  assign vld_o  = vld_q;
  assign dout_o = head_q;

endmodule

// File: rtl/parity_check.sv
// Parity checker: strips parity, flags bad words, counts errors.
// Ports: data_valid/data_in in, data_valid_out/data_out out, err_* status.
module parity_check
  import parity_pkg::*;
#(
  parameter int   DATA_WIDTH    = 8,
  parameter logic PARITY_TYPE   = PARITY_ODD,
  parameter int   ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     data_valid,
  input  logic [DATA_WIDTH:0]      data_in,
  output logic                     data_ready_out,
  output logic                     data_valid_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     parity_err_out,
  input  logic                     data_ready_in,
  input  logic                     err_clr,
  output logic                     err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE =
    ERR_CNT_WIDTH'(1);

  logic                     push;
  logic                     pop;
  logic                     word_err;
  logic                     new_err;
  logic [DATA_WIDTH:0]      buf_out;
  logic                     sticky_q;
  logic                     sticky_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_d;

  assign word_err = (PARITY_TYPE == PARITY_ODD) ?
                    ~^data_in : ^data_in;

  assign push    = data_valid & data_ready_out;
  assign pop     = data_valid_out & data_ready_in;
  assign new_err = push & word_err;

  skid_buf2 #(
    .W (DATA_WIDTH + 1)
  ) u_buf (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (push),
    .pop_i  (pop),
    .din_i  ({word_err, data_in[DATA_WIDTH-1:0]}),
    .rdy_o  (data_ready_out),
    .vld_o  (data_valid_out),
    .dout_o (buf_out)
  );

  assign data_out       = buf_out[DATA_WIDTH-1:0];
  assign parity_err_out = buf_out[DATA_WIDTH];

  // A clear coinciding with a bad word leaves that word counted.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (err_clr) begin
      sticky_d = new_err;
      cnt_d    = new_err ? CNT_ONE : '0;
    end else if (new_err) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_parity_check.sv
// Bench for parity_check: odd, even and 2-bit-counter instances
// share one stimulus stream and are checked against a queue model.
module tb_parity_check;

  localparam int DW = 8;

  logic          clk    = 1'b0;
  logic          rstn   = 1'b0;
  logic          dv     = 1'b0;
  logic          rdy_in = 1'b0;
  logic          clr    = 1'b0;
  logic [DW:0]   din    = '0;

  logic          dro_o, dvo_o, pe_o, st_o;
  logic [DW-1:0] do_o;
  logic [15:0]   cnt_o;
  logic          dro_e, dvo_e, pe_e, st_e;
  logic [DW-1:0] do_e;
  logic [15:0]   cnt_e;
  logic          dro_2, dvo_2, pe_2, st_2;
  logic [DW-1:0] do_2;
  logic [1:0]    cnt_2;

  always #5 clk = ~clk;

  parity_check u_odd (
    .clk(clk), .rstn(rstn), .data_valid(dv), .data_in(din),
    .data_ready_out(dro_o), .data_valid_out(dvo_o),
    .data_out(do_o), .parity_err_out(pe_o),
    .data_ready_in(rdy_in), .err_clr(clr),
    .err_sticky(st_o), .err_cnt(cnt_o)
  );

  parity_check #(.PARITY_TYPE(1'b0)) u_even (
    .clk(clk), .rstn(rstn), .data_valid(dv), .data_in(din),
    .data_ready_out(dro_e), .data_valid_out(dvo_e),
    .data_out(do_e), .parity_err_out(pe_e),
    .data_ready_in(rdy_in), .err_clr(clr),
    .err_sticky(st_e), .err_cnt(cnt_e)
  );

  parity_check #(.ERR_CNT_WIDTH(2)) u_w2 (
    .clk(clk), .rstn(rstn), .data_valid(dv), .data_in(din),
    .data_ready_out(dro_2), .data_valid_out(dvo_2),
    .data_out(do_2), .parity_err_out(pe_2),
    .data_ready_in(rdy_in), .err_clr(clr),
    .err_sticky(st_2), .err_cnt(cnt_2)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            ones;
  } word_t;

  word_t q[$];
  bit    m_rdy;
  int    m_cnt_o, m_cnt_e, m_cnt_2;
  bit    m_st_o, m_st_e, m_st_2;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void upd(inout int c, inout bit s,
                              input bit e, input bit cl,
                              input int mx);
    if (cl) begin
      c = e ? 1 : 0;
      s = e;
    end else if (e) begin
      s = 1'b1;
      if (c < mx) c++;
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_rdy   = 1'b0;
    m_cnt_o = 0; m_cnt_e = 0; m_cnt_2 = 0;
    m_st_o  = 0; m_st_e  = 0; m_st_2  = 0;
  endfunction

  // Odd mode: a word is bad when its total ones count is even.
  function automatic void model_edge();
    bit pu   = dv && m_rdy;
    bit po   = (q.size() > 0) && rdy_in;
    int ones = $countones(din);
    bit eo   = (ones % 2) == 0;
    word_t w;
    if (po) void'(q.pop_front());
    if (pu) begin
      w.d    = din[DW-1:0];
      w.ones = ones;
      q.push_back(w);
    end
    upd(m_cnt_o, m_st_o, pu && eo, clr, 65535);
    upd(m_cnt_e, m_st_e, pu && !eo, clr, 65535);
    upd(m_cnt_2, m_st_2, pu && eo, clr, 3);
    m_rdy = q.size() < 2;
  endfunction

  task automatic check_all();
    bit v = q.size() > 0;
    chk("odd_rdy", dro_o, m_rdy);
    chk("even_rdy", dro_e, m_rdy);
    chk("w2_rdy", dro_2, m_rdy);
    chk("odd_vld", dvo_o, v);
    chk("even_vld", dvo_e, v);
    chk("w2_vld", dvo_2, v);
    if (v) begin
      chk("odd_data", do_o, q[0].d);
      chk("even_data", do_e, q[0].d);
      chk("w2_data", do_2, q[0].d);
      chk("odd_perr", pe_o, (q[0].ones % 2) == 0);
      chk("even_perr", pe_e, (q[0].ones % 2) == 1);
      chk("w2_perr", pe_2, (q[0].ones % 2) == 0);
    end
    chk("odd_sticky", st_o, m_st_o);
    chk("even_sticky", st_e, m_st_e);
    chk("w2_sticky", st_2, m_st_2);
    chk("odd_cnt", cnt_o, m_cnt_o);
    chk("even_cnt", cnt_e, m_cnt_e);
    chk("w2_cnt", cnt_2, m_cnt_2);
  endtask

  task automatic cyc(input bit v, input logic [DW:0] d,
                     input bit r, input bit c);
    dv = v; din = d; rdy_in = r; clr = c;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #1 check_all();
    chk("rst_odd_data", do_o, 0);
    chk("rst_odd_perr", pe_o, 0);
    chk("rst_even_data", do_e, 0);
    chk("rst_w2_data", do_2, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1 check_all();
  endtask

  logic [1:0] sat_exp [5];

  initial begin
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    do_reset();
    chk("ready_low_after_release", dro_o, 0);
    cyc(0, '0, 1, 0);
    chk("ready_rise", dro_o, 1);

    cyc(1, 9'h1AA, 1, 0);
    chk("odd_1AA_data", do_o, 8'hAA);
    chk("odd_1AA_perr", pe_o, 0);
    chk("odd_1AA_cnt", cnt_o, 0);
    cyc(1, 9'h0AA, 1, 0);
    chk("odd_0AA_perr", pe_o, 1);
    chk("odd_0AA_cnt", cnt_o, 1);
    chk("odd_0AA_sticky", st_o, 1);
    chk("even_0AA_perr", pe_e, 0);
    cyc(1, 9'h0AB, 1, 0);
    chk("odd_0AB_perr", pe_o, 0);
    cyc(1, 9'h1AB, 1, 0);
    chk("even_1AB_perr", pe_e, 0);
    cyc(1, 9'h1AA, 1, 0);
    chk("even_1AA_perr", pe_e, 1);
    cyc(0, '0, 1, 0);

    cyc(1, 9'h101, 0, 0);
    cyc(1, 9'h102, 0, 0);
    chk("full_ready_low", dro_o, 0);
    cyc(1, 9'h104, 0, 0);
    chk("held_head", do_o, 8'h01);
    cyc(0, '0, 1, 0);
    chk("order_second", do_o, 8'h02);
    cyc(1, 9'h104, 1, 0);
    chk("order_third", do_o, 8'h04);
    cyc(0, '0, 1, 0);

    cyc(0, '0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 9'h003, 1, 0);
      chk("w2_sat_step", cnt_2, sat_exp[i]);
    end
    cyc(1, 9'h003, 1, 1);
    chk("clr_with_err_cnt", cnt_2, 1);
    chk("clr_with_err_sticky", st_2, 1);
    cyc(0, '0, 1, 1);
    chk("clr_alone_cnt", cnt_o, 0);
    chk("clr_alone_sticky", st_o, 0);

    cyc(1, 9'h155, 0, 0);
    cyc(1, 9'h1AA, 0, 0);
    chk("pre_rst_full", dro_o, 0);
    #2;
    do_reset();
    chk("rst_vld_drop", dvo_o, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0,
          9'($urandom_range(0, 511)),
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
